pingpong_bank_ctrl: RTL
=======================

PINGPONG_BANK_CTRL -- requirements
Module: pingpong_bank_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning bytes per bank (power of two, >= 2).
REQ-002 SHALL have parameter AW, default $clog2(DEPTH), meaning index width.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream byte present.
REQ-006 SHALL have port in_data  input  8  upstream byte.
REQ-007 SHALL have port in_ready  output  1  a byte is accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port out_ready  input  1  the downstream consumer takes the current byte.
REQ-009 SHALL have port out_valid  output  1  the read bank is full and a byte is presented.
REQ-010 SHALL have port sel  output  1  bank being drained (0 = bank0, 1 = bank1); drives the downstream registered 2:1 mux select.
REQ-011 SHALL have port subblk0  output  8  byte of bank0 at the current read index.
REQ-012 SHALL have port subblk1  output  8  byte of bank1 at the current read index.

Function
REQ-013 SHALL hold two register banks, bank0 and bank1, each DEPTH x 8 bits, plus full flags full0 and full1.
REQ-014 SHALL keep write state wbank (1 bit) and widx (AW bits); in_ready SHALL be the inverse of the full flag of wbank (combinational).
REQ-015 On an accepted byte, SHALL store in_data at bank[wbank][widx] and increment widx.
REQ-016 When the accepted byte has widx == DEPTH-1, SHALL set full[wbank], toggle wbank and clear widx to 0 on the same edge.
REQ-017 SHALL keep read state rbank (1 bit) and ridx (AW bits); sel SHALL equal rbank, and out_valid SHALL equal full[rbank].
REQ-018 subblk0 SHALL be bank0[ridx] and subblk1 SHALL be bank1[ridx], both combinational from registers; the downstream mux supplies the output register.
REQ-019 On out_valid and out_ready, SHALL increment ridx; when ridx == DEPTH-1, SHALL clear full[rbank], toggle rbank and clear ridx to 0.
REQ-020 out_ready while out_valid is low SHALL be ignored; in_valid while in_ready is low SHALL be ignored, and bank contents SHALL remain unchanged.
REQ-021 Latency: out_valid SHALL rise on the edge that writes the last byte of a bank, so it is visible in the following cycle.
REQ-022 Accepting a write to one bank and a read from the other in the same cycle SHALL both take effect, including one bank completing its fill while the other completes its drain.
REQ-023 When both banks are full, in_ready SHALL be low until the read bank drains completely; the first write after that SHALL go to the freed bank.
REQ-024 Bank order SHALL alternate strictly: bank0, bank1, bank0, ... for both fill and drain; bytes SHALL be delivered in arrival order.
REQ-025 widx and ridx SHALL wrap from DEPTH-1 to 0 only through REQ-016 and REQ-019, and never otherwise.

Reset
REQ-026 When reset is high at a rising edge, SHALL clear wbank, widx, rbank, ridx, full0 and full1 to 0; bank contents need not be cleared.
REQ-027 After reset: in_ready = 1, out_valid = 0, sel = 0.
REQ-028 Reset mid-fill or mid-drain SHALL discard all buffered data; bytes offered in the reset cycle SHALL NOT be accepted.

Structure
REQ-029 A shared package SHALL hold the byte width constant (8) and the default DEPTH, and the downstream mux SHALL use the same package.
REQ-030 The design SHALL be one flat module; a bank sub-module, pp_bank (DEPTH x 8 write port, async read), is permitted and instantiated twice.

Verification (DEPTH = 4)
REQ-031 Reset, then write 0x10..0x13 with out_ready = 0 -> out_valid = 1 next cycle, sel = 0, subblk0 = 0x10, in_ready = 1.
REQ-032 Continue with 0x20..0x23 -> full1 set, in_ready = 0; a fifth offered byte 0x30 is not accepted.
REQ-033 Then hold out_ready = 1 for 4 cycles -> subblk0 = 0x10, 0x11, 0x12, 0x13; then sel = 1 and subblk1 = 0x20; in_ready returns to 1.
REQ-034 Stream continuous in_valid and out_ready for 32 bytes 0x00..0x1F -> output is byte-identical and in order; while sel = 0, subblk0 is checked, and while sel = 1, subblk1 is checked.
REQ-035 Same-cycle final write to bank1 and final read from bank0 -> full0 = 0, full1 = 1, rbank = 1, wbank = 0 after the edge.
REQ-036 Assert reset after 2 bytes are written to bank1 while bank0 is draining -> all flags and indices are 0 next cycle, out_valid = 0, and the next byte is written to bank0[0].

Source files
------------

// File: rtl/pingpong_bank_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pingpong_bank_ctrl_pkg
// Shared constants and types for the ping-pong bank controller and the
// downstream registered 2:1 mux that consumes its sel/subblk0/subblk1 outputs.
//   BYTE_W        : width of one buffered byte (8)
//   DEFAULT_DEPTH : default number of bytes per bank (16)
//   data_t        : one byte
//   pp_mux()      : select function used by the downstream mux
// ---------------------------------------------------------------------------
package pingpong_bank_ctrl_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEFAULT_DEPTH = 16;

    typedef logic [BYTE_W-1:0] data_t;

    // Downstream mux select: sel = 0 picks bank0, sel = 1 picks bank1.
    function automatic data_t pp_mux(input logic sel, input data_t b0, input data_t b1);
        return sel ? b1 : b0;
    endfunction

endpackage

// File: rtl/pingpong_bank_ctrl_if.sv
// ---------------------------------------------------------------------------
// pingpong_bank_ctrl_if
// Upstream byte handshake plus downstream drain handshake and bank outputs.
//   in_valid / in_data / in_ready : upstream byte stream
//   out_ready / out_valid         : downstream consumer handshake
//   sel                           : bank being drained (mux select)
//   subblk0 / subblk1             : bank0 / bank1 byte at the read index
// Modports: master = traffic source/sink side, slave = controller side.
// ---------------------------------------------------------------------------
interface pingpong_bank_ctrl_if;
    import pingpong_bank_ctrl_pkg::*;

    logic  in_valid;
    data_t in_data;
    logic  in_ready;
    logic  out_ready;
    logic  out_valid;
    logic  sel;
    data_t subblk0;
    data_t subblk1;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sel, subblk0, subblk1
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sel, subblk0, subblk1
    );

endinterface

// File: rtl/pp_bank.sv
// ---------------------------------------------------------------------------
// pp_bank
// One DEPTH x 8 register bank: synchronous write port, asynchronous read.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write byte
//   raddr : read index
//   rdata : byte at raddr (combinational)
// ---------------------------------------------------------------------------
module pp_bank
    import pingpong_bank_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  data_t         wdata,
    input  logic [AW-1:0] raddr,
    output data_t         rdata
);

    data_t mem_q [DEPTH];

    // NOTE: storage is never reset; the full flags alone decide whether the
    // contents mean anything, so a reset here would only cost flops.
    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pingpong_bank_ctrl.sv
// ---------------------------------------------------------------------------
// pingpong_bank_ctrl
// Two-bank ping-pong byte buffer. Bytes fill bank0, then bank1, alternately;
// a bank becomes readable once its last byte is written and is released once
// its last byte is consumed. Fill and drain proceed in parallel on opposite
// banks.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : pingpong_bank_ctrl_if.slave (see interface for signal list)
// ---------------------------------------------------------------------------
module pingpong_bank_ctrl
    import pingpong_bank_ctrl_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    pingpong_bank_ctrl_if.slave  bus
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic          wbank_q, wbank_d;
    logic [AW-1:0] widx_q,  widx_d;
    logic          rbank_q, rbank_d;
    logic [AW-1:0] ridx_q,  ridx_d;
    logic [1:0]    full_q,  full_d;

    logic wr_fire;
    logic rd_fire;

    assign bus.in_ready  = ~full_q[wbank_q];
    assign bus.out_valid = full_q[rbank_q];
    assign bus.sel       = rbank_q;

    assign wr_fire = bus.in_valid & bus.in_ready;
    assign rd_fire = bus.out_valid & bus.out_ready;

    // A write needs full[wbank] = 0 and a read needs full[rbank] = 1, so when
    // both fire they always target different banks and never collide on full_d.
    // NOTE: every output of this block gets its default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        wbank_d = wbank_q;
        widx_d  = widx_q;
        rbank_d = rbank_q;
        ridx_d  = ridx_q;
        full_d  = full_q;

        if (wr_fire) begin
            if (widx_q == LAST_IDX) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = ~wbank_q;
                widx_d          = '0;
            end else begin
                widx_d = widx_q + AW'(1);
            end
        end

        if (rd_fire) begin
            if (ridx_q == LAST_IDX) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = ~rbank_q;
                ridx_d          = '0;
            end else begin
                ridx_d = ridx_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbank_q <= 1'b0;
            widx_q  <= '0;
            rbank_q <= 1'b0;
            ridx_q  <= '0;
            full_q  <= '0;
        end else begin
            wbank_q <= wbank_d;
            widx_q  <= widx_d;
            rbank_q <= rbank_d;
            ridx_q  <= ridx_d;
            full_q  <= full_d;
        end
    end

    // Writes are suppressed during reset so a byte offered in the reset cycle
    // leaves no trace.
    logic we0, we1;
    assign we0 = wr_fire & ~wbank_q & ~reset;
    assign we1 = wr_fire &  wbank_q & ~reset;

    pp_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (widx_q),
        .wdata (bus.in_data),
        .raddr (ridx_q),
        .rdata (bus.subblk0)
    );

    pp_bank #(.DEPTH(DEPTH), .AW(AW)) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (widx_q),
        .wdata (bus.in_data),
        .raddr (ridx_q),
        .rdata (bus.subblk1)
    );

endmodule
